// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the flag bundle.
// Pure declarations; no latency or backpressure of its own.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_PASS_B = 4'd0,
    ALU_INC_A  = 4'd1,
    ALU_ADD    = 4'd2,
    ALU_SHL    = 4'd3,
    ALU_SUB    = 4'd4,
    ALU_SHR    = 4'd5,
    ALU_DEC_A  = 4'd6,
    ALU_CLR    = 4'd7,
    ALU_MUL    = 4'd8
  } alu_op_t;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } alu_state_t;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the control unit (master) and the ALU (slave).
// sat_flag exists only when ALU_SAT_EN is defined; no backpressure beyond busy.
interface alu_seq_if import alu_pkg::*; #(
  parameter int WIDTH = 8
);
  logic             start;
  alu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] g;
  logic             c_flag;
  logic             z_flag;
  logic             n_flag;
  logic             v_flag;
`ifdef ALU_SAT_EN
  logic             sat_flag;
`endif

  modport master (
    output start, op, a, b,
`ifdef ALU_SAT_EN
    input  sat_flag,
`endif
    input  busy, done, g, c_flag, z_flag, n_flag, v_flag
  );

  modport slave (
    input  start, op, a, b,
`ifdef ALU_SAT_EN
    output sat_flag,
`endif
    output busy, done, g, c_flag, z_flag, n_flag, v_flag
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: load captures operands, each step retires one multiplier bit.
// prod_next/last are combinational so the caller can register the product on the final step.
module alu_mul_iter #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] prod_next
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;

  // Upper half accumulates the multiplicand; the lower half holds the unconsumed multiplier bits.
  assign sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
  assign prod_next = {sum, acc[WIDTH-1:1]};
  assign last      = step && (cnt == CW'(CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, b};
      mcand <= a;
      cnt   <= '0;
    end else if (step) begin
      acc   <= prod_next;
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops give done one edge after start; MUL takes WIDTH+1 edges, start ignored while busy.
// ALU_SAT_EN makes ADD/INC_A/SUB/DEC_A saturate unsigned and adds sat_flag.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam int             M   = WIDTH - 1;
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  alu_state_t         state;
  logic               busy_q;
  logic               done_q;
  logic [M:0]         g_q;
  flags_t             flags_q;

  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH:0]     sum;
  logic [M:0]         res;
  logic               res_c;
  logic               res_v;
  flags_t             res_flags;
`ifdef ALU_SAT_EN
  logic               sat;
  logic               sat_q;
`endif

  assign mul_load = (state == IDLE) && bus.start && (bus.op == ALU_MUL);
  assign mul_step = (state == MUL_RUN);

  alu_mul_iter #(
    .WIDTH  (WIDTH),
    .CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load),
    .step      (mul_step),
    .a         (bus.a),
    .b         (bus.b),
    .last      (mul_last),
    .prod_next (prod)
  );

  always_comb begin
    sum   = '0;
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
`ifdef ALU_SAT_EN
    sat   = 1'b0;
`endif
    if (state == MUL_RUN) begin
      res   = prod[M:0];
      res_c = |prod[2*WIDTH-1:WIDTH];
    end else begin
      case (bus.op)
        ALU_PASS_B: res = bus.b;
        ALU_INC_A: begin
          sum   = {1'b0, bus.a} + ONE;
          res   = sum[M:0];
          res_c = sum[WIDTH];
        end
        ALU_ADD: begin
          sum   = {1'b0, bus.a} + {1'b0, bus.b};
          res   = sum[M:0];
          res_c = sum[WIDTH];
          res_v = (bus.a[M] == bus.b[M]) && (sum[M] != bus.a[M]);
        end
        ALU_SHL: begin
          res   = {bus.a[M-1:0], 1'b0};
          res_c = bus.a[M];
        end
        ALU_SUB: begin
          sum   = {1'b0, bus.a} - {1'b0, bus.b};
          res   = sum[M:0];
          res_c = sum[WIDTH];
          res_v = (bus.a[M] != bus.b[M]) && (sum[M] != bus.a[M]);
        end
        ALU_SHR: begin
          res   = {1'b0, bus.a[M:1]};
          res_c = bus.a[0];
        end
        ALU_DEC_A: begin
          sum   = {1'b0, bus.a} - ONE;
          res   = sum[M:0];
          res_c = sum[WIDTH];
        end
        default: res = '0;
      endcase
`ifdef ALU_SAT_EN
      // C keeps the raw carry/borrow; only the result is clamped.
      if (res_c && (bus.op == ALU_ADD || bus.op == ALU_INC_A)) begin
        res = '1;
        sat = 1'b1;
      end else if (res_c && (bus.op == ALU_SUB || bus.op == ALU_DEC_A)) begin
        res = '0;
        sat = 1'b1;
      end
`endif
    end
    res_flags = '{c: res_c, z: (res == '0), n: res[M], v: res_v};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      g_q     <= '0;
      flags_q <= '0;
`ifdef ALU_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.op == ALU_MUL) begin
              busy_q <= 1'b1;
              state  <= MUL_RUN;
            end else begin
              g_q     <= res;
              flags_q <= res_flags;
              done_q  <= 1'b1;
`ifdef ALU_SAT_EN
              sat_q   <= sat;
`endif
            end
          end
        end
        MUL_RUN: begin
          if (mul_last) begin
            g_q     <= res;
            flags_q <= res_flags;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
`ifdef ALU_SAT_EN
            sat_q   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.g      = g_q;
  assign bus.c_flag = flags_q.c;
  assign bus.z_flag = flags_q.z;
  assign bus.n_flag = flags_q.n;
  assign bus.v_flag = flags_q.v;
`ifdef ALU_SAT_EN
  assign bus.sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8; expectations are hand-computed, with
// saturating variants selected when ALU_SAT_EN is defined.
`ifdef ALU_SAT_EN
`define EXP_SAT(x) , x
`else
`define EXP_SAT(x)
`endif

module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(
    .WIDTH      (8),
    .MUL_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flg();
    return {bus.c_flag, bus.z_flag, bus.n_flag, bus.v_flag};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ef = {c, z, n, v}
  task automatic issue(input string tag, input alu_op_t op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] eg, input logic [3:0] ef
`ifdef ALU_SAT_EN
                       , input logic es
`endif
                       );
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    check({tag, ".done"}, bus.done, 1);
    check({tag, ".g"}, bus.g, eg);
    check({tag, ".flags"}, flg(), ef);
`ifdef ALU_SAT_EN
    check({tag, ".sat"}, bus.sat_flag, es);
`endif
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    int done_seen;

    bus.start = 1'b0;
    bus.op    = ALU_CLR;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    check("rst.g", bus.g, 0);
    check("rst.flags", flg(), 0);
    check("rst.done", bus.done, 0);
    check("rst.busy", bus.busy, 0);
    rst = 1'b0;
    tick();

    issue("add_7f_01", ALU_ADD, 8'h7F, 8'h01, 8'h80, 4'b0011 `EXP_SAT(1'b0));
    tick();
    check("add_7f_01.done_pulse", bus.done, 0);
    check("add_7f_01.hold", bus.g, 8'h80);

    issue("sub_05_05", ALU_SUB, 8'h05, 8'h05, 8'h00, 4'b0100 `EXP_SAT(1'b0));
    issue("sub_80_01", ALU_SUB, 8'h80, 8'h01, 8'h7F, 4'b0001 `EXP_SAT(1'b0));
    issue("pass_b", ALU_PASS_B, 8'h11, 8'h9C, 8'h9C, 4'b0010 `EXP_SAT(1'b0));
    issue("clr", ALU_CLR, 8'hFF, 8'hFF, 8'h00, 4'b0100 `EXP_SAT(1'b0));
    issue("op12", alu_op_t'(4'd12), 8'h05, 8'h05, 8'h00, 4'b0100 `EXP_SAT(1'b0));
`ifdef ALU_SAT_EN
    issue("sub_03_05", ALU_SUB, 8'h03, 8'h05, 8'h00, 4'b1100, 1'b1);
    issue("dec_00", ALU_DEC_A, 8'h00, 8'h00, 8'h00, 4'b1100, 1'b1);
    issue("inc_ff", ALU_INC_A, 8'hFF, 8'h00, 8'hFF, 4'b1010, 1'b1);
    issue("add_80_80", ALU_ADD, 8'h80, 8'h80, 8'hFF, 4'b1011, 1'b1);
`else
    issue("sub_03_05", ALU_SUB, 8'h03, 8'h05, 8'hFE, 4'b1010);
    issue("dec_00", ALU_DEC_A, 8'h00, 8'h00, 8'hFF, 4'b1010);
    issue("inc_ff", ALU_INC_A, 8'hFF, 8'h00, 8'h00, 4'b1100);
    issue("add_80_80", ALU_ADD, 8'h80, 8'h80, 8'h00, 4'b1101);
`endif
    tick();

    // Back-to-back: one result per cycle, done held high across all three.
    issue("b2b_shl", ALU_SHL, 8'h81, 8'h00, 8'h02, 4'b1000 `EXP_SAT(1'b0));
    issue("b2b_shr", ALU_SHR, 8'h81, 8'h00, 8'h40, 4'b1000 `EXP_SAT(1'b0));
    issue("b2b_pass", ALU_PASS_B, 8'h81, 8'h00, 8'h00, 4'b0100 `EXP_SAT(1'b0));
    tick();
    check("b2b.done_end", bus.done, 0);

    // Multiply with a start attempted mid-run.
    bus.start = 1'b1;
    bus.op    = ALU_MUL;
    bus.a     = 8'h10;
    bus.b     = 8'h11;
    tick();
    bus.start = 1'b0;
    check("mul.busy", bus.busy, 1);
    check("mul.done_early", bus.done, 0);
    busy_cnt = 1;
    cyc      = 0;
    while (!bus.done && cyc < 20) begin
      if (cyc == 2) begin
        bus.start = 1'b1;
        bus.op    = ALU_MUL;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      cyc++;
      if (bus.busy) busy_cnt++;
    end
    bus.start = 1'b0;
    check("mul.latency", cyc, 8);
    check("mul.busy_cycles", busy_cnt, 8);
    check("mul.g", bus.g, 8'h10);
    check("mul.flags", flg(), 4'b1000);
    check("mul.busy_end", bus.busy, 0);
    tick();
    check("mul.no_second_done", bus.done, 0);
    check("mul.hold", bus.g, 8'h10);

    // Reset in the middle of a multiply.
    bus.start = 1'b1;
    bus.op    = ALU_MUL;
    bus.a     = 8'h03;
    bus.b     = 8'h03;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    check("mrst.g", bus.g, 0);
    check("mrst.flags", flg(), 0);
    check("mrst.busy", bus.busy, 0);
    check("mrst.done", bus.done, 0);
    #2 rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      tick();
      if (bus.done) done_seen++;
    end
    check("mrst.no_done", done_seen, 0);
    check("mrst.busy_after", bus.busy, 0);
    issue("mrst.add_2_3", ALU_ADD, 8'h02, 8'h03, 8'h05, 4'b0000 `EXP_SAT(1'b0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
